// File: rtl/srl_seq.sv
// Multi-cycle right shifter/rotator: logical, arithmetic or rotate right by cnt bits.
// Define SRL_SEQ_FAST4_EN to step four bits per clock while at least four remain.
module srl_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] rem;
    logic [1:0]       mode;

    logic             fill;
    logic [WIDTH-1:0] step;
    logic [CNT_W-1:0] rem_nxt;
    logic             accept;

    // Handshake: start is taken on any edge where busy=0 (IDLE or DONE);
    // done is a one-cycle pulse and out holds its value until the next result.
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign accept = start && (state != SHIFT);

    always_comb begin
        fill    = (mode == MODE_ASR) && work[WIDTH-1];
        step    = (mode == MODE_ROR) ? {work[0], work[WIDTH-1:1]}
                                     : {fill, work[WIDTH-1:1]};
        rem_nxt = rem - CNT_W'(1);
`ifdef SRL_SEQ_FAST4_EN
        if (rem >= CNT_W'(4)) begin
            step    = (mode == MODE_ROR) ? {work[3:0], work[WIDTH-1:4]}
                                         : {{4{fill}}, work[WIDTH-1:4]};
            rem_nxt = rem - CNT_W'(4);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            mode  <= MODE_LSR;
            out   <= '0;
        end else if (accept) begin
            work <= in;
            rem  <= cnt;
            // op=11 is folded into logical right at capture time
            mode <= (op == 2'b11) ? MODE_LSR : op;
            if (cnt == '0) begin
                out   <= in;
                state <= DONE;
            end else begin
                state <= SHIFT;
            end
        end else begin
            case (state)
                SHIFT: begin
                    work <= step;
                    rem  <= rem_nxt;
                    if (rem_nxt == '0) begin
                        out   <= step;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srl_seq.sv
// Self-checking bench for srl_seq: vector table, hand sequences and random ops
// against a scoreboard queue of expected results and latencies.
module tb_srl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [15:0] out;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    srl_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in),
        .cnt   (cnt),
        .op    (op),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [15:0] d;
        logic [3:0]  c;
        logic [1:0]  o;
        logic [15:0] e;
    } vec_t;

    vec_t        vecs[13];
    logic [15:0] exp_q[$];
    int          lat_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c);
`ifdef SRL_SEQ_FAST4_EN
        return int'(c) / 4 + int'(c) % 4 + 1;
`else
        return int'(c) + 1;
`endif
    endfunction

    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] c,
                                          input logic [1:0] o);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(c); i++) begin
            case (o)
                2'b01:   r = {d[15], r[15:1]};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic drive_start(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
        in    = d;
        cnt   = c;
        op    = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in    = 16'($urandom);
        cnt   = 4'($urandom);
        op    = 2'($urandom);
    endtask

    task automatic launch(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                          input logic [15:0] e);
        exp_q.push_back(e);
        lat_q.push_back(exp_lat(c));
        drive_start(d, c, o);
    endtask

    // elapsed = number of post-start negedges already seen (all of them busy but the current one)
    task automatic wait_result(input string name, input int elapsed);
        int          cycles;
        int          bc;
        logic [15:0] e;
        int          l;
        cycles = elapsed;
        bc     = elapsed - 1;
        while (!done && cycles < 64) begin
            if (busy) bc++;
            @(negedge clk);
            cycles++;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        if (!done) begin
            check({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " out"}, out, e);
            check({name, " latency"}, cycles, l);
            check({name, " busy cycles"}, bc, l - 1);
        end
    endtask

    initial begin
        int    seen;
        string nm;
        logic [15:0] d;
        logic [3:0]  c;
        logic [1:0]  o;

        vecs[0]  = '{16'hF00F, 4'd4,  2'b00, 16'h0F00};
        vecs[1]  = '{16'h8001, 4'd15, 2'b01, 16'hFFFF};
        vecs[2]  = '{16'h4000, 4'd14, 2'b01, 16'h0001};
        vecs[3]  = '{16'h0001, 4'd1,  2'b10, 16'h8000};
        vecs[4]  = '{16'h8000, 4'd3,  2'b11, 16'h1000};
        vecs[5]  = '{16'h8000, 4'd9,  2'b01, 16'hFFC0};
        vecs[6]  = '{16'h1234, 4'd4,  2'b10, 16'h4123};
        vecs[7]  = '{16'h8001, 4'd15, 2'b10, 16'h0003};
        vecs[8]  = '{16'h7FFF, 4'd3,  2'b01, 16'h0FFF};
        vecs[9]  = '{16'hABCD, 4'd15, 2'b00, 16'h0001};
        vecs[10] = '{16'hABCD, 4'd8,  2'b10, 16'hCDAB};
        vecs[11] = '{16'h9999, 4'd0,  2'b01, 16'h9999};
        vecs[12] = '{16'h8000, 4'd15, 2'b01, 16'hFFFF};

        rst_n = 1'b0;
        start = 1'b0;
        in    = '0;
        cnt   = '0;
        op    = '0;
        #12;
        check("reset out", out, 16'h0000);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            nm = $sformatf("vec%0d", i);
            launch(vecs[i].d, vecs[i].c, vecs[i].o, vecs[i].e);
            wait_result(nm, 1);
            @(negedge clk);
            check({nm, " done pulse"}, done, 1'b0);
            check({nm, " out hold"}, out, vecs[i].e);
        end

        // cnt=0 followed by a start in the DONE cycle
        launch(16'h1234, 4'd0, 2'b00, 16'h1234);
        wait_result("b2b first", 1);
        launch(16'h00F0, 4'd4, 2'b00, 16'h000F);
        wait_result("b2b second", 1);
        @(negedge clk);

        // start pulsed while busy must not disturb the operation
        launch(16'hFFFF, 4'd8, 2'b00, 16'h00FF);
        @(negedge clk);
        in    = 16'h0000;
        cnt   = 4'd1;
        op    = 2'b10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignore", 3);
        @(negedge clk);

        // asynchronous reset mid-operation
        drive_start(16'hFFFF, 4'd8, 2'b00);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out", out, 16'h0000);
        check("async rst busy", busy, 1'b0);
        check("async rst done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("no done after reset", seen, 0);

        for (int i = 0; i < 20; i++) begin
            d  = 16'($urandom);
            c  = 4'($urandom_range(0, 15));
            o  = 2'($urandom_range(0, 3));
            nm = $sformatf("rand%0d", i);
            launch(d, c, o, model(d, c, o));
            wait_result(nm, 1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
